sample_hist_display: RTL and testbench

SAMPLE_HIST_DISPLAY -- requirements
Module: sample_hist_display

---
 rtl/sample_hist_display_pkg.sv | 43 ++++
 rtl/bcd7seg.sv | 19 +
 rtl/btn_debounce.sv | 74 +++++++
 rtl/sample_hist_display.sv | 140 ++++++++++++++
 tb/tb_sample_hist_display.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sample_hist_display_pkg.sv
// ---------------------------------------------------------------------------
// sample_hist_display_pkg
// Shared constants for the sample history display:
//   DEPTH      - number of history entries kept by the display
//   PTR_W      - width of the history write/read pointers
//   SEG_BLANK  - segment pattern with every segment dark (active-low)
//   SEG_TABLE  - 16-entry nibble-to-segment table, active-low, gfedcba
// ---------------------------------------------------------------------------
package sample_hist_display_pkg;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry 15 is written first, so SEG_TABLE[n] is the glyph for nibble n.
  // Glyphs 0-9 are the usual decimal digits; 10-15 render as A b C d E F.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E,  // F
    7'h06,  // E
    7'h21,  // d
    7'h46,  // C
    7'h03,  // b
    7'h08,  // A
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

  // Table lookup wrapped as a function so callers never index the
  // constant with a mismatched width.
  function automatic logic [6:0] nibble_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/bcd7seg.sv
// ---------------------------------------------------------------------------
// bcd7seg
// Purely combinational nibble to seven-segment decoder, extended past the
// decimal range so 10-15 show as hex letters. Blanking is the caller's job.
// Ports:
//   nibble - 4-bit value to display
//   seg    - active-low segments, gfedcba order
// ---------------------------------------------------------------------------
module bcd7seg
  import sample_hist_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Straight table lookup; no state and no blanking here.
  assign seg = nibble_to_seg(nibble);

endmodule

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Turns a raw, asynchronous push button into a clean one-cycle step pulse.
// The button is double-flopped into the clk domain, then a counter requires
// DEBOUNCE_CYC consecutive synchronized samples that disagree with the
// current debounced level before that level is allowed to flip. Only the
// 0->1 flip of the debounced level produces a pulse.
// Ports:
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset
//   btn_raw - raw button input, any timing
//   step    - one-cycle pulse per accepted press
// ---------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic step
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync_meta;
  logic             sync_out;
  logic             level;
  logic [CNT_W-1:0] stable_cnt;
  logic             accept;

  // The counter has already seen DEBOUNCE_CYC-1 disagreeing samples, and
  // this one disagrees too, so the level flips on this edge.
  assign accept = (sync_out != level) && (stable_cnt == CNT_LAST);

  // Two-flop synchronizer bringing the button into the clk domain. The
  // first flop may go metastable; only the second is ever looked at.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
    end else begin
      sync_meta <= btn_raw;
      sync_out  <= sync_meta;
    end
  end

  // Debounce counter: any sample matching the current level restarts the
  // count, so only an unbroken run of disagreeing samples moves the level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt <= '0;
      level      <= 1'b0;
    end else if (sync_out == level) begin
      stable_cnt <= '0;
    end else if (accept) begin
      stable_cnt <= '0;
      level      <= sync_out;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

  // Rising-edge detector on the debounced level. Because the level is
  // cleared by reset, leaving reset can never look like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step <= 1'b0;
    end else begin
      step <= accept & sync_out;
    end
  end

endmodule

// File: rtl/sample_hist_display.sv
// ---------------------------------------------------------------------------
// sample_hist_display
// Keeps the last DEPTH sample bytes and shows one of them on two hex digits.
// In live mode (freeze=0) new samples are stored and the newest one is
// shown. In browse mode (freeze=1) storage is paused and each debounced
// press of btn_next steps one entry further back, wrapping at the number of
// stored entries.
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   din       - sample byte
//   din_valid - din carries a sample this cycle
//   btn_next  - raw push button stepping the history view
//   freeze    - 1 = browse history, 0 = live
//   hex0      - low-nibble segments, active-low gfedcba
//   hex1      - high-nibble segments, active-low gfedcba
//   view_age  - age of the shown entry, 0 = newest
//   count     - number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module sample_hist_display #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int DEPTH        = sample_hist_display_pkg::DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_valid,
  input  logic       btn_next,
  input  logic       freeze,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [1:0] view_age,
  output logic [2:0] count
);

  import sample_hist_display_pkg::*;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic             freeze_q;
  logic             step;
  logic             wr_en;
  logic             freeze_rise;
  logic [2:0]       age_inc;
  logic [PTR_W-1:0] rd_idx;
  logic [7:0]       shown;
  logic [6:0]       seg_lo;
  logic [6:0]       seg_hi;

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_btn (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_next),
    .step   (step)
  );

  // A sample arriving in the same cycle that freeze goes high is dropped
  // simply because freeze already gates the write.
  assign wr_en       = din_valid & ~freeze;
  assign freeze_rise = freeze & ~freeze_q;
  assign age_inc     = {1'b0, view_age} + 3'd1;

  // Newest entry sits just behind the write pointer; older ones further
  // back. Pointer arithmetic wraps naturally at the pointer width.
  assign rd_idx = wr_ptr - PTR_W'(1) - view_age;
  assign shown  = mem[rd_idx];

  bcd7seg u_seg_lo (
    .nibble(shown[3:0]),
    .seg   (seg_lo)
  );

  bcd7seg u_seg_hi (
    .nibble(shown[7:4]),
    .seg   (seg_hi)
  );

  // History storage. Deliberately not reset: while count is zero the
  // display is forced blank, so stale contents can never be seen.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

  // Write pointer and fill level. Once full, the pointer keeps going round
  // and overwrites the oldest entry while count stays at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (count != 3'(DEPTH)) begin
        count <= count + 3'd1;
      end
    end
  end

  // Freeze edge tracking so every entry into browse mode starts at the
  // newest entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freeze_q <= 1'b0;
    end else begin
      freeze_q <= freeze;
    end
  end

  // View age: pinned to zero in live mode and on entering browse mode;
  // otherwise each step walks one entry older, wrapping at count. With one
  // or no stored entries there is nothing to step through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      view_age <= '0;
    end else if (!freeze || freeze_rise) begin
      view_age <= '0;
    end else if (step && (count > 3'd1)) begin
      view_age <= (age_inc == count) ? 2'd0 : age_inc[1:0];
    end
  end

  // Registered display so the segment outputs are glitch-free. An empty
  // history shows a dark display instead of whatever memory holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex0 <= SEG_BLANK;
      hex1 <= SEG_BLANK;
    end else if (count == 3'd0) begin
      hex0 <= SEG_BLANK;
      hex1 <= SEG_BLANK;
    end else begin
      hex0 <= seg_lo;
      hex1 <= seg_hi;
    end
  end

endmodule

// File: tb/tb_sample_hist_display.sv
// ---------------------------------------------------------------------------
// tb_sample_hist_display
// Directed bench for sample_hist_display. A small reference model tracks
// the history, fill level and view age; expected outputs are queued when
// stimulus is driven and popped when the display is due to show them.
// ---------------------------------------------------------------------------
module tb_sample_hist_display;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       btn_next = 1'b0;
  logic       freeze = 1'b0;
  logic [6:0] hex0;
  logic [6:0] hex1;
  logic [1:0] view_age;
  logic [2:0] count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [6:0] h1;
    logic [6:0] h0;
    logic [1:0] age;
    logic [2:0] cnt;
  } exp_t;

  exp_t sb[$];

  logic [7:0] mem_m [4];
  int         wrp_m = 0;
  int         cnt_m = 0;
  int         age_m = 0;
  bit         frz_prev = 1'b0;

  sample_hist_display #(
    .DEBOUNCE_CYC(DB),
    .DEPTH       (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .din_valid(din_valid),
    .btn_next (btn_next),
    .freeze   (freeze),
    .hex0     (hex0),
    .hex1     (hex1),
    .view_age (view_age),
    .count    (count)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Reference glyphs, active-low gfedcba.
  function automatic logic [6:0] refSeg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Snapshot what the display should show according to the model.
  function automatic void pushExpect(input string tag);
    exp_t       e;
    logic [7:0] b;
    e.tag = tag;
    e.age = 2'(age_m);
    e.cnt = 3'(cnt_m);
    if (cnt_m == 0) begin
      e.h1 = 7'h7F;
      e.h0 = 7'h7F;
    end else begin
      b    = mem_m[(wrp_m + 4 - 1 - age_m) % 4];
      e.h1 = refSeg(b[7:4]);
      e.h0 = refSeg(b[3:0]);
    end
    sb.push_back(e);
  endfunction

  function automatic void modelReset();
    wrp_m    = 0;
    cnt_m    = 0;
    age_m    = 0;
    frz_prev = 1'b0;
  endfunction

  // Compare the oldest queued expectation with the live outputs.
  task automatic checkOutput();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries expected at least 1");
      return;
    end
    e = sb.pop_front();
    checks += 3;
    assert (hex1 === e.h1) else begin
      errors++;
      $error("[TB] FAIL %s hex1: got %h expected %h", e.tag, hex1, e.h1);
    end
    assert (hex0 === e.h0) else begin
      errors++;
      $error("[TB] FAIL %s hex0: got %h expected %h", e.tag, hex0, e.h0);
    end
    assert (view_age === e.age) else begin
      errors++;
      $error("[TB] FAIL %s view_age: got %0d expected %0d", e.tag, view_age, e.age);
    end
    assert (count === e.cnt) else begin
      errors++;
      $error("[TB] FAIL %s count: got %0d expected %0d", e.tag, count, e.cnt);
    end
  endtask

  // Drive one cycle of inputs and advance the model across that edge.
  task automatic applyStimulus(input bit dv, input logic [7:0] d,
                               input bit frz, input bit b);
    din_valid = dv;
    din       = d;
    freeze    = frz;
    btn_next  = b;
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (dv && !frz) begin
        mem_m[wrp_m] = d;
        wrp_m        = (wrp_m + 1) % 4;
        if (cnt_m < 4) cnt_m++;
      end
      if (!frz || !frz_prev) age_m = 0;
      frz_prev = frz;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 8'h00, freeze, 1'b0);
  endtask

  // Hold the button for n_high cycles, release, and wait for everything to
  // settle including the release debounce.
  task automatic pressButton(input int n_high);
    repeat (n_high) applyStimulus(1'b0, 8'h00, freeze, 1'b1);
    repeat (14) applyStimulus(1'b0, 8'h00, freeze, 1'b0);
    if (n_high >= DB && freeze && cnt_m > 1) age_m = (age_m + 1) % cnt_m;
  endtask

  task automatic writeByte(input logic [7:0] d);
    applyStimulus(1'b1, d, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    pushExpect("reset");
    checkOutput();
    rst_n = 1'b1;
    idle(2);

    // Press with empty history
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    pressButton(6);
    pushExpect("press_cnt0");
    checkOutput();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    // Single write shown one cycle later
    writeByte(8'h3C);
    pushExpect("write_3c");
    idle(1);
    checkOutput();

    // Press with a single entry
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    pressButton(6);
    pushExpect("press_cnt1");
    checkOutput();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    // Overfill the history
    for (int i = 1; i <= 5; i++) writeByte(8'(i));
    pushExpect("fill_05");
    idle(1);
    checkOutput();

    // Browse back three entries, then wrap
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    idle(1);
    for (int i = 0; i < 4; i++) begin
      pressButton(6);
      pushExpect($sformatf("browse_%0d", i));
      checkOutput();
    end

    // Short glitch is ignored, a real press steps once
    pressButton(3);
    pushExpect("glitch");
    checkOutput();
    pressButton(6);
    pushExpect("press_6cyc");
    checkOutput();

    // Writes while frozen are ignored
    repeat (3) applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0);
    idle(1);
    pushExpect("frozen_wr");
    checkOutput();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    idle(1);
    pushExpect("live_again");
    checkOutput();

    // Freeze rising with a sample in the same cycle drops it
    applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0);
    idle(1);
    pushExpect("coincident");
    checkOutput();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    idle(1);
    pushExpect("after_coinc");
    checkOutput();

    // Browse to age 2, start a press, then reset between clock edges
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    pressButton(6);
    pressButton(6);
    pushExpect("age2");
    checkOutput();
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    pushExpect("async_reset");
    checkOutput();
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    modelReset();
    rst_n = 1'b1;
    idle(14);
    pushExpect("post_reset");
    checkOutput();

    // History works again after reset
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    writeByte(8'h7A);
    pushExpect("write_7a");
    idle(1);
    checkOutput();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
